// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory port, execute redirect and the decode handshake.
// master = the fetch unit, slave = memory/execute/decode side.
interface instruction_fetch_unit_if;
   logic        imem_read;
   logic [31:0] imem_addr;
   logic [31:0] imem_instruction;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic [31:0] out_pc;

   modport master (
      output imem_read, imem_addr, out_valid, out_instruction, out_pc,
      input  imem_instruction, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_read, imem_addr, out_valid, out_instruction, out_pc,
      output imem_instruction, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Stage-1 fetch: owns the PC, tracks one in-flight read and buffers {pc, instruction} pairs for decode.
// Optional JAL_PREDECODE_EN macro adds a JAL target predecode on the returning instruction.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   instruction_fetch_unit_if.master   bus
);

   if (BUF_DEPTH != 2) begin : g_depth_check
      $error("instruction_fetch_unit supports BUF_DEPTH=2 only");
   end
   if (RESET_PC[1:0] != 2'b00) begin : g_pc_check
      $error("instruction_fetch_unit RESET_PC must be word aligned");
   end

   logic [31:0] pc_q, pc_d;
   logic [31:0] infl_pc_q, infl_pc_d;
   logic        inflight_q, inflight_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] e0_instr_q, e0_instr_d, e0_pc_q, e0_pc_d;
   logic [31:0] e1_instr_q, e1_instr_d, e1_pc_q, e1_pc_d;

   logic        deq, enq, issue;
   logic [2:0]  occupancy;
   logic [1:0]  fill;

`ifdef JAL_PREDECODE_EN
   logic        jal_taken;
   logic [31:0] jal_target;
   logic [31:0] jal_offset;
`endif

   always_comb begin
      deq       = (count_q != 2'd0) & bus.out_ready;
      // Credit check counts the in-flight return so the buffer can never overflow.
      occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, deq};
      issue     = !reset & !bus.redirect_valid & (occupancy < 3'd2);
      enq       = inflight_q & !bus.redirect_valid;
   end

`ifdef JAL_PREDECODE_EN
   always_comb begin
      jal_offset = {{11{bus.imem_instruction[31]}}, bus.imem_instruction[31],
                    bus.imem_instruction[19:12], bus.imem_instruction[20],
                    bus.imem_instruction[30:21], 1'b0};
      jal_target = infl_pc_q + jal_offset;
      jal_taken  = enq & (bus.imem_instruction[6:0] == 7'b1101111);
   end
`endif

   always_comb begin
      pc_d       = pc_q;
      infl_pc_d  = infl_pc_q;
      inflight_d = issue;
      if (issue) begin
         pc_d      = pc_q + 32'd4;
         infl_pc_d = pc_q;
      end
`ifdef JAL_PREDECODE_EN
      // The sequential fetch issued alongside a taken JAL is squashed by dropping its in-flight flag.
      if (jal_taken) begin
         pc_d       = jal_target;
         inflight_d = 1'b0;
      end
`endif
      if (bus.redirect_valid) begin
         pc_d       = bus.redirect_pc & 32'hFFFF_FFFC;
         inflight_d = 1'b0;
      end
   end

   always_comb begin
      e0_instr_d = e0_instr_q;
      e0_pc_d    = e0_pc_q;
      e1_instr_d = e1_instr_q;
      e1_pc_d    = e1_pc_q;
      fill       = count_q;
      count_d    = count_q;
      if (bus.redirect_valid) begin
         count_d = 2'd0;
      end else begin
         if (deq) begin
            e0_instr_d = e1_instr_q;
            e0_pc_d    = e1_pc_q;
            fill       = count_q - 2'd1;
         end
         if (enq) begin
            if (fill == 2'd0) begin
               e0_instr_d = bus.imem_instruction;
               e0_pc_d    = infl_pc_q;
            end else begin
               e1_instr_d = bus.imem_instruction;
               e1_pc_d    = infl_pc_q;
            end
            fill = fill + 2'd1;
         end
         count_d = fill;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         infl_pc_q  <= 32'd0;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
         e0_instr_q <= 32'd0;
         e0_pc_q    <= 32'd0;
         e1_instr_q <= 32'd0;
         e1_pc_q    <= 32'd0;
      end else begin
         pc_q       <= pc_d;
         infl_pc_q  <= infl_pc_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         e0_instr_q <= e0_instr_d;
         e0_pc_q    <= e0_pc_d;
         e1_instr_q <= e1_instr_d;
         e1_pc_q    <= e1_pc_d;
      end
   end

   a_no_overflow : assert property (@(posedge clock) disable iff (reset)
      !(enq && !deq && count_q == 2'd2));

   assign bus.imem_read       = issue;
   assign bus.imem_addr       = pc_q;
   assign bus.out_valid       = (count_q != 2'd0);
   assign bus.out_instruction = e0_instr_q;
   assign bus.out_pc          = e0_pc_q;

endmodule
